// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state codes, port indices,
// priority modes and the address range check helper.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Word-aligned and inside the memory; addr is a byte address.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way winner selection between fetch (I) and data (D) with a turn pointer.
// PRIO_MODE selects fixed priority (D wins ties) or round-robin.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic clk,
  input  logic reset,
  input  logic i_reqI,
  input  logic i_reqD,
  input  logic i_enable,
  output logic o_valid,
  output logic o_winner
);

  logic r_ptr;

  always_comb begin
    o_valid  = i_reqI | i_reqD;
    o_winner = PORT_I;
    if (i_reqI && i_reqD) begin
      o_winner = (PRIO_MODE == PRIO_FIXED) ? PORT_D : r_ptr;
    end else if (i_reqD) begin
      o_winner = PORT_D;
    end
  end

  // Every grant, including a lone request, hands the next tie to the other port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= PORT_I;
    end else if (i_enable && o_valid) begin
      r_ptr <= ~o_winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto the single unified memory.
// Optional macro MEM_ARB_ADDR_CHECK_EN rejects misaligned or out-of-range accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16384,
  parameter int          PRIO_MODE = PRIO_RR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  logic [1:0]  r_state;
  logic        r_winner;
  logic        r_we;
  logic        r_reject;
  logic [31:0] r_memAddr;
  logic [31:0] r_memDin;
  logic [31:0] r_iRdata;
  logic [31:0] r_dRdata;

  logic        w_arbEn;
  logic        w_grantValid;
  logic        w_grantWinner;
  logic [31:0] w_addr;
  logic        w_addrOk;
  logic        w_reject;

  assign w_arbEn = (r_state == IDLE);

  rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_reqI   (i_req),
    .i_reqD   (d_req),
    .i_enable (w_arbEn),
    .o_valid  (w_grantValid),
    .o_winner (w_grantWinner)
  );

  assign w_addr   = (w_grantWinner == PORT_D) ? d_addr : i_addr;
  assign w_addrOk = addr_in_range(w_addr, MEM_DEPTH);

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign w_reject = ~w_addrOk;
`else
  assign w_reject = 1'b0 & ~w_addrOk;
`endif

  // IDLE latches the winning request, ACCESS drives the memory, RESP acks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_winner  <= PORT_I;
      r_we      <= 1'b0;
      r_reject  <= 1'b0;
      r_memAddr <= '0;
      r_memDin  <= '0;
      r_iRdata  <= '0;
      r_dRdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_state   <= ACCESS;
            r_winner  <= w_grantWinner;
            r_we      <= (w_grantWinner == PORT_D) && d_we;
            r_reject  <= w_reject;
            r_memAddr <= w_addr;
            if (w_grantWinner == PORT_D) begin
              r_memDin <= d_wdata;
            end
          end
        end
        ACCESS: begin
          r_state <= RESP;
          if (!r_we) begin
            if (r_winner == PORT_I) begin
              r_iRdata <= r_reject ? 32'h0 : mem_dout;
            end else begin
              r_dRdata <= r_reject ? 32'h0 : mem_dout;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so a reset drops them without a clock edge.
  assign mem_read  = (r_state == ACCESS) && !r_we && !r_reject;
  assign mem_write = (r_state == ACCESS) &&  r_we && !r_reject;
  assign mem_addr  = r_memAddr;
  assign mem_din   = r_memDin;
  assign i_ack     = (r_state == RESP) && (r_winner == PORT_I);
  assign d_ack     = (r_state == RESP) && (r_winner == PORT_D);
  assign err       = (r_state == RESP) && r_reject;
  assign i_rdata   = r_iRdata;
  assign d_rdata   = r_dRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance on a small memory model
// and a fixed-priority instance whose memory returns the inverted address.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, err, mem_read, mem_write;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  logic        fReqI = 1'b0, fReqD = 1'b0;
  logic [31:0] fAddrI = '0, fAddrD = '0;
  logic        fAckI, fAckD, fErr, fRead, fWrite;
  logic [31:0] fRdataI, fRdataD, fMemAddr, fMemDin, fMemDout;

  logic [31:0] mem [0:63];
  logic        tbWrEn = 1'b0;
  logic [5:0]  tbWrIdx = '0;
  logic [31:0] tbWrData = '0;
  int          wrCount = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_din;
      wrCount++;
    end else if (tbWrEn) begin
      mem[tbWrIdx] <= tbWrData;
    end
  end
  assign mem_dout = mem[mem_addr[7:2]];
  assign fMemDout = ~fMemAddr;

  mem_arbiter #(.MEM_DEPTH(16384), .PRIO_MODE(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  mem_arbiter #(.MEM_DEPTH(16384), .PRIO_MODE(0)) dutFixed (
    .clk(clk), .reset(reset),
    .i_req(fReqI), .i_addr(fAddrI), .i_ack(fAckI), .i_rdata(fRdataI),
    .d_req(fReqD), .d_we(1'b0), .d_addr(fAddrD), .d_wdata(32'h0),
    .d_ack(fAckD), .d_rdata(fRdataD), .err(fErr),
    .mem_addr(fMemAddr), .mem_din(fMemDin), .mem_read(fRead),
    .mem_write(fWrite), .mem_dout(fMemDout)
  );

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({i_ack, d_ack, err, mem_read, mem_write} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000", {i_ack, d_ack, err, mem_read, mem_write});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus: addr=%h din=%h expected 0", mem_addr, mem_din);
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    @(negedge clk);
    tbWrEn = 1'b1; tbWrIdx = 6'd4; tbWrData = 32'hDEADBEEF;
    @(negedge clk);
    tbWrEn = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_lone_fetch();
    i_req = 1'b1; i_addr = 32'h10;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_read !== (k == 1)) begin
        errors++;
        $display("[TB] FAIL fetch_mem_read c%0d: got %b expected %b", k, mem_read, k == 1);
      end
      checks++;
      if (i_ack !== (k == 2) || d_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fetch_ack c%0d: i_ack=%b d_ack=%b expected %b 0", k, i_ack, d_ack, k == 2);
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 32'h10) begin
          errors++;
          $display("[TB] FAIL fetch_addr: got %h expected 00000010", mem_addr);
        end
      end
      if (k == 2) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF || err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fetch_rdata: got %h err=%b expected deadbeef err=0", i_rdata, err);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_load();
    int startCount;
    startCount = wrCount;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_din !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL store_access: wr=%b rd=%b din=%h expected 1 0 12345678", mem_write, mem_read, mem_din);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || mem_write !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_ack: ack=%b wr=%b err=%b expected 1 0 0", d_ack, mem_write, err);
    end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_access: rd=%b wr=%b expected 1 0", mem_read, mem_write);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL load_data: ack=%b data=%h expected 1 12345678", d_ack, d_rdata);
    end
    d_req = 1'b0;
    checks++;
    if (wrCount - startCount !== 1) begin
      errors++;
      $display("[TB] FAIL store_write_count: got %0d expected 1", wrCount - startCount);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic expI, expD;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      expI = (k == 2) || (k == 8);
      expD = (k == 5) || (k == 11);
      checks++;
      if (i_ack !== expI || d_ack !== expD) begin
        errors++;
        $display("[TB] FAIL rr_grant c%0d: i_ack=%b d_ack=%b expected %b %b", k, i_ack, d_ack, expI, expD);
      end
      if (k == 8) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("[TB] FAIL rr_i_rdata: got %h expected deadbeef", i_rdata);
        end
      end
      if (k == 11) begin
        checks++;
        if (d_rdata !== 32'h12345678) begin
          errors++;
          $display("[TB] FAIL rr_d_rdata: got %h expected 12345678", d_rdata);
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    logic expI, expD;
    fReqI = 1'b1; fAddrI = 32'h40;
    fReqD = 1'b1; fAddrD = 32'h44;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expD = (k == 2);
      expI = (k == 5);
      checks++;
      if (fAckI !== expI || fAckD !== expD) begin
        errors++;
        $display("[TB] FAIL fixed_grant c%0d: i_ack=%b d_ack=%b expected %b %b", k, fAckI, fAckD, expI, expD);
      end
      if (k == 2) begin
        checks++;
        if (fRdataD !== 32'hFFFFFFBB) begin
          errors++;
          $display("[TB] FAIL fixed_d_rdata: got %h expected ffffffbb", fRdataD);
        end
        fReqD = 1'b0;
      end
      if (k == 5) begin
        checks++;
        if (fRdataI !== 32'hFFFFFFBF) begin
          errors++;
          $display("[TB] FAIL fixed_i_rdata: got %h expected ffffffbf", fRdataI);
        end
        fReqI = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_write: got %b expected 1", mem_write);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_read, i_ack, d_ack, err} !== 5'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL abort_clear: strobes=%b addr=%h expected 00000 0", {mem_write, mem_read, i_ack, d_ack, err}, mem_addr);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h20;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("[TB] FAIL post_reset_tie: i_ack=%b d_ack=%b data=%h expected 1 0 deadbeef", i_ack, d_ack, i_rdata);
        end
        i_req = 1'b0;
      end
      if (k == 5) begin
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
          errors++;
          $display("[TB] FAIL post_reset_load: ack=%b data=%h expected 1 12345678", d_ack, d_rdata);
        end
        d_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_addr_check();
    logic sawStrobe;
`ifdef MEM_ARB_ADDR_CHECK_EN
    sawStrobe = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
    @(negedge clk);
    sawStrobe = mem_read | mem_write;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0 || sawStrobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_load: ack=%b err=%b data=%h strobe=%b expected 1 1 0 0", d_ack, err, d_rdata, sawStrobe);
    end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd65536; d_wdata = 32'h0BADF00D;
    @(negedge clk);
    sawStrobe = mem_read | mem_write;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b1 || sawStrobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_store: ack=%b err=%b strobe=%b expected 1 1 0", d_ack, err, sawStrobe);
    end
    d_req = 1'b0; d_we = 1'b0;
`else
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    sawStrobe = mem_read;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h12345678 || sawStrobe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_check_load: ack=%b err=%b data=%h rd=%b expected 1 0 12345678 1", d_ack, err, d_rdata, sawStrobe);
    end
    d_req = 1'b0;
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_round_robin();
    test_fixed_prio();
    test_async_reset();
    test_addr_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
